elevator_queue_ctrl: RTL and testbench
======================================

# elevator_queue_ctrl

Request queue and car-motion controller for a single four-floor elevator. Sits directly downstream of the new-level filter. It accepts the filter's `add_new_lvl` strobe, appends `pressed_lvl` to a 4-entry in-order queue, and drives the car floor by floor toward the queue head. It opens the door on arrival and retires the head entry. It exports `queue` and `tail` back to the filter so duplicate requests are suppressed.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 8: cycles to move one floor; must be ≥1.
- `DOOR_CYCLES`, default 16: cycles the door stays open; must be ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1: sole clock, rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `add_new_lvl`  input  1: push strobe from the filter, valid for one cycle.
- `pressed_lvl`  input  2: level to push; sampled when `add_new_lvl`=1.
- `queue`  output  8: entry i occupies bits [2i+1:2i]; entry 0 is the head.
- `tail`  output  3: occupancy count, 0..4.
- `cur_lvl`  output  2: floor the car is at.
- `moving`  output  1: 1 in MOVE_UP/MOVE_DOWN.
- `door_open`  output  1: 1 in DOOR.
- `overflow`  output  1: one-cycle pulse when a push is dropped because the queue is full.

## Operation
- Queue is a shift structure. A push writes at `tail`. A pop shifts entries down by one. Entries at index ≥ `tail` are driven to 0.
- Push with `tail`=4 and no pop in the same cycle: entry dropped, `overflow`=1 for that cycle.
- Push and pop in the same cycle:
  - Shift, then write at `tail`−1; `tail` unchanged.
  - Legal even when `tail`=4.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
  - IDLE, `tail`=0: stay.
  - IDLE, `tail`>0, head==`cur_lvl`: go to DOOR.
  - IDLE, `tail`>0, head>`cur_lvl`: go to MOVE_UP.
  - IDLE, `tail`>0, head<`cur_lvl`: go to MOVE_DOWN.
  - MOVE_*: the travel counter counts 0..TRAVEL_CYCLES−1. At terminal count, `cur_lvl` ±1 and the counter clears. If the new floor equals the head, go to DOOR; otherwise continue.
  - DOOR: the door counter counts 0..DOOR_CYCLES−1. At terminal count, pop the head and go to IDLE.
- Head target is latched on entry to MOVE_*/DOOR. A push never changes the head, so no retargeting occurs.
- `cur_lvl` never wraps; 2-bit arithmetic, floors 0..3 only.
- The queue never holds duplicates, because upstream filters against `queue`/`tail`. The block does not re-check.

## Timing
- Reset values: `queue`=0, `tail`=0, `cur_lvl`=0, state IDLE, both counters 0, `moving`=0, `door_open`=0, `overflow`=0.
- All outputs are registered; `overflow` may be the registered push-drop condition.
- A push at cycle N appears in `queue`/`tail` at N+1. The filter sees it one cycle later, so a repeat press at N+1 must be accepted by the filter only if it is not yet in the queue.
- IDLE reacts to non-empty `tail` one cycle after it becomes visible.
- A one-floor move takes TRAVEL_CYCLES cycles in MOVE_*. Total time from push into an empty queue to `door_open`=1 is 2 + d·TRAVEL_CYCLES cycles, where d is the floor distance.
- `door_open` is high for exactly DOOR_CYCLES cycles. Pop and return to IDLE happen on the last cycle's edge.
- Reset asserted mid-operation clears everything immediately, with no pending-pop completion. Release is synchronised by the standard reset scheme.

## Structure
- The shared package holds:
  - `LVL_W`=2, `QDEPTH`=4, `TAIL_W`=3;
  - the state enum `ctrl_state_t` {IDLE, MOVE_UP, MOVE_DOWN, DOOR}.
- Natural sub-module: `lvl_queue`, the 4-entry shift queue with push/pop/overflow logic. The FSM, counters and `cur_lvl` stay in the top.

## Test plan
- Reset, push lvl 2 with TRAVEL_CYCLES=8 and DOOR_CYCLES=16 → `tail`=1 next cycle; `moving` for 16 cycles; `cur_lvl`=2; `door_open` for 16 cycles; then `tail`=0 and `queue`=0.
- Push 3, 1, 0, 2 on consecutive cycles at `cur_lvl`=0 → `queue`=8'b10_00_01_11, `tail`=4. Visit order is 3, 1, 0, 2; `cur_lvl` steps 0→1→2→3→2→1→0→1→2.
- Fill to 4 and push again with no pop → `overflow`=1 for one cycle; `queue`/`tail` unchanged.
- With `tail`=4, push on the final DOOR cycle → pop and push in the same cycle; `tail` stays 4; the new level lands at entry 3.
- Push lvl 0 while at floor 0 in IDLE → DOOR entered with no motion; `moving` never asserted.
- Assert `rst_n`=0 mid-MOVE_UP → all outputs zero asynchronously; after release, the block stays idle until the next push.

Source files
------------

// File: rtl/elevator_queue_ctrl_pkg.sv
// Shared widths, depth and FSM state type for the elevator request controller.
package elevator_queue_ctrl_pkg;

    localparam int LVL_W  = 2;
    localparam int QDEPTH = 4;
    localparam int TAIL_W = 3;

    // Occupancy value meaning "every entry is in use".
    localparam logic [TAIL_W-1:0] TAIL_FULL = TAIL_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/elevator_queue_ctrl_queue.sv
// Four-entry in-order level queue. Entry 0 is the head; a pop shifts the
// remaining entries down, a push writes at the current occupancy. A push
// that coincides with a pop lands one slot lower so it is never lost.
module lvl_queue
    import elevator_queue_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [LVL_W-1:0]      push_lvl,
    input  logic                  pop,
    output logic [2*QDEPTH-1:0]   queue,
    output logic [TAIL_W-1:0]     tail,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(QDEPTH);

    logic [LVL_W-1:0]  ent_q [QDEPTH];
    logic [LVL_W-1:0]  ent_d [QDEPTH];
    logic [TAIL_W-1:0] tail_q;
    logic [TAIL_W-1:0] tail_d;
    logic              ovf_d;
    logic [IDX_W-1:0]  wr_idx;

    // Next queue contents: shift on pop, then place any push at the free slot.
    always_comb begin
        ent_d  = ent_q;
        tail_d = tail_q;
        ovf_d  = 1'b0;
        wr_idx = tail_q[IDX_W-1:0];
        if (pop && (tail_q != '0)) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[QDEPTH-1] = '0;
            if (push) begin
                wr_idx        = IDX_W'(tail_q - 3'd1);
                ent_d[wr_idx] = push_lvl;
            end else begin
                tail_d = tail_q - 3'd1;
            end
        end else if (push) begin
            if (tail_q == TAIL_FULL) begin
                ovf_d = 1'b1;
            end else begin
                ent_d[wr_idx] = push_lvl;
                tail_d        = tail_q + 3'd1;
            end
        end
    end

    // Queue storage, occupancy and the registered drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                ent_q[i] <= '0;
            end
            tail_q   <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            tail_q   <= tail_d;
            overflow <= ovf_d;
        end
    end

    // Flatten the entries into the exported bus, head in the low bits.
    always_comb begin
        queue = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            queue[LVL_W*i +: LVL_W] = ent_q[i];
        end
    end

    assign tail = tail_q;

endmodule

// File: rtl/elevator_queue_ctrl.sv
// Single-car, four-floor elevator controller: queues requested levels and
// walks the car one floor at a time to the queue head, holding the door open
// on arrival before retiring that request.
module elevator_queue_ctrl
    import elevator_queue_ctrl_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  add_new_lvl,
    input  logic [LVL_W-1:0]      pressed_lvl,
    output logic [2*QDEPTH-1:0]   queue,
    output logic [TAIL_W-1:0]     tail,
    output logic [LVL_W-1:0]      cur_lvl,
    output logic                  moving,
    output logic                  door_open,
    output logic                  overflow
);

    localparam int TC_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRAVEL_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DOOR_CYCLES - 1);

    ctrl_state_t       state_q, state_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic [LVL_W-1:0]  lvl_d;
    logic [LVL_W-1:0]  target_q, target_d;
    logic [LVL_W-1:0]  head;
    logic              pop;

    lvl_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (add_new_lvl),
        .push_lvl (pressed_lvl),
        .pop      (pop),
        .queue    (queue),
        .tail     (tail),
        .overflow (overflow)
    );

    assign head = queue[LVL_W-1:0];

    // Next state, counters and floor; the head is captured as the target when
    // leaving IDLE, so later pushes cannot redirect a trip in progress.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        lvl_d    = cur_lvl;
        target_d = target_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (tail != '0) begin
                    target_d = head;
                    if (head == cur_lvl) begin
                        state_d = DOOR;
                    end else if (head > cur_lvl) begin
                        state_d = MOVE_UP;
                    end else begin
                        state_d = MOVE_DOWN;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tcnt_q == TC_LAST) begin
                    tcnt_d = '0;
                    lvl_d  = (state_q == MOVE_UP) ? cur_lvl + 2'd1 : cur_lvl - 2'd1;
                    if (lvl_d == target_q) begin
                        state_d = DOOR;
                    end
                end else begin
                    tcnt_d = tcnt_q + TC_W'(1);
                end
            end
            DOOR: begin
                if (dcnt_q == DC_LAST) begin
                    dcnt_d  = '0;
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + DC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; moving/door_open are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            cur_lvl   <= '0;
            target_q  <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            cur_lvl   <= lvl_d;
            target_q  <= target_d;
            moving    <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
            door_open <= (state_d == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// Self-checking bench for elevator_queue_ctrl: directed scenarios with literal
// expectations plus randomized pushes compared every cycle to a trip-level model.
`timescale 1ns/1ps
module tb_elevator_queue_ctrl;

    localparam int T = 8;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       add_new_lvl = 1'b0;
    logic [1:0] pressed_lvl = 2'd0;
    logic [7:0] queue;
    logic [2:0] tail;
    logic [1:0] cur_lvl;
    logic       moving;
    logic       door_open;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    elevator_queue_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .add_new_lvl (add_new_lvl),
        .pressed_lvl (pressed_lvl),
        .queue       (queue),
        .tail        (tail),
        .cur_lvl     (cur_lvl),
        .moving      (moving),
        .door_open   (door_open),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A trip is described by its start cycle, start floor, target and distance;
    // outputs for any cycle follow arithmetically from the elapsed time.
    int mq[$];
    int cyc = 0;
    int m_floor = 0;
    bit m_busy = 0;
    int m_start = 0, m_f0 = 0, m_tgt = 0, m_d = 0;
    int e_floor = 0, e_moving = 0, e_door = 0, e_ovf = 0;
    bit idle_prev;
    bit popped;
    int rel;

    function automatic logic [7:0] pack_q();
        logic [7:0] v;
        int x;
        v = 8'd0;
        for (int i = 0; i < mq.size(); i++) begin
            x = mq[i];
            v[2*i +: 2] = x[1:0];
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_floor = 0; m_busy = 0;
            e_floor = 0; e_moving = 0; e_door = 0; e_ovf = 0;
        end else begin
            cyc++;
            idle_prev = !m_busy;
            popped = 0;
            if (m_busy && (cyc - 1 == m_start + m_d*T + D - 1)) begin
                popped  = 1;
                m_busy  = 0;
                m_floor = m_tgt;
                void'(mq.pop_front());
            end
            if (idle_prev && mq.size() > 0) begin
                m_busy  = 1;
                m_start = cyc;
                m_f0    = m_floor;
                m_tgt   = mq[0];
                m_d     = (m_tgt > m_f0) ? m_tgt - m_f0 : m_f0 - m_tgt;
            end
            e_ovf = 0;
            if (add_new_lvl) begin
                if (popped || mq.size() < 4) mq.push_back(int'(pressed_lvl));
                else e_ovf = 1;
            end
            if (m_busy) begin
                rel = cyc - m_start;
                if (rel < m_d*T) begin
                    e_moving = 1; e_door = 0;
                    e_floor  = m_f0 + ((m_tgt > m_f0) ? 1 : -1) * (rel / T);
                end else begin
                    e_moving = 0; e_door = 1; e_floor = m_tgt;
                end
            end else begin
                e_moving = 0; e_door = 0; e_floor = m_floor;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_queue",     int'(queue),     int'(pack_q()));
            check("m_tail",      int'(tail),      mq.size());
            check("m_cur_lvl",   int'(cur_lvl),   e_floor);
            check("m_moving",    int'(moving),    e_moving);
            check("m_door_open", int'(door_open), e_door);
            check("m_overflow",  int'(overflow),  e_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic reset_dut();
        add_new_lvl = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_push(input int lvl);
        add_new_lvl = 1'b1;
        pressed_lvl = 2'(lvl);
        @(negedge clk);
        add_new_lvl = 1'b0;
    endtask

    int mv, dr, dc, prev_f, prev_d, lvl;
    bit hit, allow;
    int floors[$];
    int doors[$];
    int exp_f[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_d[4] = '{3, 1, 0, 2};

    initial begin
        // Reset values
        reset_dut();
        check("rst_queue", int'(queue), 0);
        check("rst_tail", int'(tail), 0);
        check("rst_cur_lvl", int'(cur_lvl), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_overflow", int'(overflow), 0);

        // Single request to floor 2
        do_push(2);
        check("a_tail_next", int'(tail), 1);
        mv = 0; dr = 0;
        repeat (60) begin
            @(negedge clk);
            mv += int'(moving);
            dr += int'(door_open);
        end
        check("a_moving_cycles", mv, 2*T);
        check("a_door_cycles", dr, D);
        check("a_cur_lvl", int'(cur_lvl), 2);
        check("a_tail_end", int'(tail), 0);
        check("a_queue_end", int'(queue), 0);

        // Four requests, overflow, visit order
        reset_dut();
        do_push(3); do_push(1); do_push(0); do_push(2);
        check("b_queue_full", int'(queue), 8'b10_00_01_11);
        check("b_tail_full", int'(tail), 4);
        do_push(1);
        check("b_overflow", int'(overflow), 1);
        check("b_queue_kept", int'(queue), 8'b10_00_01_11);
        check("b_tail_kept", int'(tail), 4);
        @(negedge clk);
        check("b_overflow_drop", int'(overflow), 0);
        floors.delete(); doors.delete();
        prev_f = int'(cur_lvl); prev_d = int'(door_open);
        repeat (200) begin
            @(negedge clk);
            if (int'(cur_lvl) != prev_f) floors.push_back(int'(cur_lvl));
            if (door_open && prev_d == 0) doors.push_back(int'(cur_lvl));
            prev_f = int'(cur_lvl);
            prev_d = int'(door_open);
        end
        check("b_floor_steps", floors.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("b_floor_%0d", i), (i < floors.size()) ? floors[i] : -1, exp_f[i]);
        check("b_door_visits", doors.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b_visit_%0d", i), (i < doors.size()) ? doors[i] : -1, exp_d[i]);

        // Push on the last door cycle while full
        reset_dut();
        do_push(3); do_push(1); do_push(0); do_push(2);
        hit = 0; dc = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (door_open) begin
                dc++;
                if (dc == D) begin
                    do_push(3);
                    hit = 1;
                end
            end
            if (!hit) @(negedge clk);
        end
        check("c_reached_last_door", int'(hit), 1);
        check("c_tail", int'(tail), 4);
        check("c_queue", int'(queue), 8'b11_10_00_01);
        check("c_door_closed", int'(door_open), 0);
        repeat (20) @(negedge clk);

        // Request for the current floor: door without motion
        reset_dut();
        do_push(0);
        mv = 0; dr = 0;
        repeat (40) begin
            @(negedge clk);
            mv += int'(moving);
            dr += int'(door_open);
        end
        check("d_moving_cycles", mv, 0);
        check("d_door_cycles", dr, D);
        check("d_cur_lvl", int'(cur_lvl), 0);
        check("d_tail", int'(tail), 0);

        // Asynchronous reset in the middle of an upward move
        reset_dut();
        do_push(3);
        repeat (5) @(negedge clk);
        check("e_moving_before", int'(moving), 1);
        #2 rst_n = 1'b0;
        #1;
        check("e_async_queue", int'(queue), 0);
        check("e_async_tail", int'(tail), 0);
        check("e_async_cur", int'(cur_lvl), 0);
        check("e_async_moving", int'(moving), 0);
        check("e_async_door", int'(door_open), 0);
        check("e_async_ovf", int'(overflow), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mv = 0;
        repeat (20) begin
            @(negedge clk);
            mv += int'(moving) + int'(door_open);
        end
        check("e_idle_after", mv, 0);
        check("e_tail_after", int'(tail), 0);
        check("e_cur_after", int'(cur_lvl), 0);

        // Randomized requests, mostly filtered like the upstream block would
        reset_dut();
        repeat (3000) begin
            add_new_lvl = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                lvl = int'($urandom_range(0, 3));
                allow = 1;
                foreach (mq[i]) if (mq[i] == lvl) allow = 0;
                if ($urandom_range(0, 9) == 0) allow = 1;
                add_new_lvl = allow;
                pressed_lvl = 2'(lvl);
            end
            @(negedge clk);
        end
        add_new_lvl = 1'b0;
        repeat (200) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
